// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings for the param_stack LIFO.
package stack_pkg;

  localparam logic [1:0] OP_POP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_PEEK    = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register file, one synchronous write port and
// one combinational read port. Contents are never reset.
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // write port; the read below sees the old word in the same cycle
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with POP/PUSH/PEEK/REPLACE and occupancy count.
// Optional sticky overflow/underflow flags with clear input when STACK_ERR_EN
// is defined.
module param_stack
  import stack_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef STACK_ERR_EN
  input  logic             err_clr,
  output logic [1:0]       error,
`endif
  input  logic             enable,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] top_idx;
  logic [CNT_W-1:0] waddr_full;
  logic             we;
  logic [WIDTH-1:0] rdata;

  assign top_idx = sp_q - CNT_W'(1);
  assign full    = (sp_q == CNT_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign count   = sp_q;
  assign data_out = dout_q;

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (we && !rst),
    .waddr_i (waddr_full[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (top_idx[AW-1:0]),
    .rdata_o (rdata)
  );

  // operation decode: pointer, write strobe and read-data next state
  always_comb begin
    sp_d       = sp_q;
    dout_d     = dout_q;
    we         = 1'b0;
    waddr_full = sp_q;
    if (enable) begin
      case (operation)
        OP_PUSH: begin
          if (!full) begin
            we   = 1'b1;
            sp_d = sp_q + CNT_W'(1);
          end
        end
        OP_POP: begin
          if (!empty) begin
            dout_d = rdata;
            sp_d   = top_idx;
          end
        end
        OP_PEEK: begin
          if (!empty) dout_d = rdata;
        end
        default: begin // OP_REPLACE; on an empty stack it is a plain push
          we = 1'b1;
          if (empty) begin
            sp_d = sp_q + CNT_W'(1);
          end else begin
            waddr_full = top_idx;
            dout_d     = rdata;
          end
        end
      endcase
    end
  end

  // pointer and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
    end
  end

`ifdef STACK_ERR_EN
  logic [1:0] err_q, err_d;

  // sticky flags; a new event in the clearing cycle still sets its bit
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = '0;
    if (enable && (operation == OP_PUSH) && full) err_d[ERR_OVF] = 1'b1;
    if (enable && ((operation == OP_POP) || (operation == OP_PEEK)) && empty)
      err_d[ERR_UNF] = 1'b1;
  end

  // error flag register
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign error = err_q;
`endif

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed checks on a 16x8 stack plus a randomised run on a
// 5x5 stack against a queue model. Error flags checked when STACK_ERR_EN set.
module tb_param_stack;
  import stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  operation = 2'b00;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        full, empty;
  logic [3:0]  count;

  logic        s_en = 1'b0;
  logic [1:0]  s_op = 2'b00;
  logic [4:0]  s_din = '0;
  logic [4:0]  s_dout;
  logic        s_full, s_empty;
  logic [2:0]  s_count;

`ifdef STACK_ERR_EN
  logic       err_clr = 1'b0;
  logic [1:0] error;
  logic [1:0] s_error;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_stack #(.WIDTH(16), .DEPTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef STACK_ERR_EN
    .err_clr   (err_clr),
    .error     (error),
`endif
    .enable    (enable),
    .operation (operation),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  param_stack #(.WIDTH(5), .DEPTH(5)) u_small (
    .clk       (clk),
    .rst       (rst),
`ifdef STACK_ERR_EN
    .err_clr   (1'b0),
    .error     (s_error),
`endif
    .enable    (s_en),
    .operation (s_op),
    .data_in   (s_din),
    .data_out  (s_dout),
    .full      (s_full),
    .empty     (s_empty),
    .count     (s_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive one cycle of stimulus, return at the following negedge
  task automatic cyc(input logic e, input logic [1:0] o, input logic [15:0] d);
    enable = e; operation = o; data_in = d;
    @(negedge clk);
    enable = 1'b0;
  endtask

  logic [4:0] q[$];
  logic [4:0] m_dout;

  initial begin
    @(negedge clk);
    cyc(0, OP_POP, 16'h0);
    rst = 1'b0;
    cyc(0, OP_PUSH, 16'hFFFF);
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_count", 32'(count), 32'h0);

    for (int i = 1; i <= 8; i++) begin
      cyc(1, OP_PUSH, 16'(i * 16'h1111));
      chk("push_count", 32'(count), 32'(i));
      chk("push_dout", 32'(data_out), 32'h0);
    end
    chk("fill_full", 32'(full), 32'h1);
    cyc(1, OP_PUSH, 16'h9999);
    chk("ovf_count", 32'(count), 32'h8);
    chk("ovf_full", 32'(full), 32'h1);
`ifdef STACK_ERR_EN
    chk("ovf_err", 32'(error), 32'h1);
    err_clr = 1'b1;
    cyc(0, OP_POP, 16'h0);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(error), 32'h0);
`endif
    for (int i = 8; i >= 1; i--) begin
      cyc(1, OP_POP, 16'h0);
      chk("pop_dout", 32'(data_out), 32'(i * 16'h1111));
      chk("pop_count", 32'(count), 32'(i - 1));
    end
    chk("drain_empty", 32'(empty), 32'h1);

    cyc(1, OP_PUSH, 16'hAAAA);
    chk("pk_push_dout", 32'(data_out), 32'h1111);
    cyc(1, OP_PEEK, 16'h0);
    chk("peek_dout", 32'(data_out), 32'hAAAA);
    chk("peek_count", 32'(count), 32'h1);
    cyc(1, OP_REPLACE, 16'hBBBB);
    chk("repl_dout", 32'(data_out), 32'hAAAA);
    chk("repl_count", 32'(count), 32'h1);
    cyc(1, OP_POP, 16'h0);
    chk("repl_pop", 32'(data_out), 32'hBBBB);
    chk("repl_end_count", 32'(count), 32'h0);

    cyc(1, OP_PUSH, 16'h1234);
    cyc(1, OP_POP, 16'h0);
    chk("unf_setup", 32'(data_out), 32'h1234);
    cyc(1, OP_POP, 16'h0);
    chk("unf_dout", 32'(data_out), 32'h1234);
    chk("unf_count", 32'(count), 32'h0);
    cyc(1, OP_PEEK, 16'h0);
    chk("unf_peek_dout", 32'(data_out), 32'h1234);
`ifdef STACK_ERR_EN
    chk("unf_err", 32'(error), 32'h2);
    cyc(0, OP_POP, 16'h0);
    chk("unf_sticky", 32'(error), 32'h2);
    err_clr = 1'b1;
    cyc(1, OP_POP, 16'h0);
    chk("clr_vs_set", 32'(error), 32'h2);
    cyc(0, OP_POP, 16'h0);
    err_clr = 1'b0;
    chk("unf_clr", 32'(error), 32'h0);
`endif

    cyc(1, OP_PUSH, 16'h0001);
    cyc(1, OP_PUSH, 16'h0002);
    cyc(1, OP_PUSH, 16'h0003);
    chk("pre_rst_count", 32'(count), 32'h3);
    rst = 1'b1;
    cyc(1, OP_PUSH, 16'h7777);
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_empty", 32'(empty), 32'h1);
    chk("mid_rst_dout", 32'(data_out), 32'h0);
    cyc(1, OP_PUSH, 16'h5555);
    cyc(1, OP_POP, 16'h0);
    chk("post_rst_pop", 32'(data_out), 32'h5555);
    chk("post_rst_count", 32'(count), 32'h0);

    cyc(1, OP_REPLACE, 16'h0C0C);
    chk("repl_empty_count", 32'(count), 32'h1);
    chk("repl_empty_dout", 32'(data_out), 32'h5555);
    for (int i = 0; i < 7; i++) cyc(1, OP_PUSH, 16'(16'h0100 + i));
    chk("refill_full", 32'(full), 32'h1);
    cyc(1, OP_REPLACE, 16'hFFFF);
    chk("repl_full_dout", 32'(data_out), 32'h0106);
    chk("repl_full_count", 32'(count), 32'h8);
    for (int i = 0; i < 7; i++) cyc(1, OP_POP, 16'h0);
    chk("pop_top_after_repl", 32'(count), 32'h1);
    cyc(1, OP_POP, 16'h0);
    chk("repl_empty_pop", 32'(data_out), 32'h0C0C);
    chk("final_empty", 32'(empty), 32'h1);

    // randomised run on the 5x5 instance, which has been idle since reset
    m_dout = '0;
    for (int n = 0; n < 3000; n++) begin
      s_en  = ($urandom_range(0, 3) != 0);
      s_op  = 2'($urandom_range(0, 3));
      s_din = 5'($urandom_range(0, 31));
      if (s_en) begin
        case (s_op)
          OP_PUSH: if (q.size() < 5) q.push_back(s_din);
          OP_POP:  if (q.size() > 0) m_dout = q.pop_back();
          OP_PEEK: if (q.size() > 0) m_dout = q[q.size() - 1];
          default: begin
            if (q.size() == 0) q.push_back(s_din);
            else begin
              m_dout = q[q.size() - 1];
              q[q.size() - 1] = s_din;
            end
          end
        endcase
      end
      @(negedge clk);
      chk("rnd_dout", 32'(s_dout), 32'(m_dout));
      chk("rnd_count", 32'(s_count), 32'(q.size()));
      chk("rnd_full", 32'(s_full), 32'(q.size() == 5));
      chk("rnd_empty", 32'(s_empty), 32'(q.size() == 0));
    end
    s_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
